serdes_lpbk_bist: RTL and testbench

Parametrised on-chip loopback BIST engine for the SerDes PHY. It drives a PRBS7 or PRBS15 word stream into the PCS TX parallel port with a valid/ready handshake, and checks the RX parallel stream with a self-synchronising checker. It declares sync, counts bit errors over a programmed word window and reports pass/fail/timeout. It sits beside `u_pcs` in `u_top`, is controlled from the I2C register file, and replaces external stimulus for production loopback test.

---
 rtl/serdes_bist_pkg.sv | 32 +++
 rtl/serdes_prbs_gen.sv | 51 +++++
 rtl/serdes_lpbk_bist.sv | 253 +++++++++++++++++++++++++
 tb/tb_serdes_lpbk_bist.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/serdes_bist_pkg.sv
// Shared types and PRBS constants for the SerDes loopback BIST engine.
package serdes_bist_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SYNC  = 2'd1,
      ST_CHECK = 2'd2,
      ST_DONE  = 2'd3
   } bist_state_e;

   localparam int PRBS7_LEN    = 7;
   localparam int PRBS15_LEN   = 15;
   localparam int PRBS_HIST_W  = PRBS15_LEN;
   localparam int PRBS7_TAP_A  = PRBS7_LEN - 1;
   localparam int PRBS7_TAP_B  = PRBS7_LEN - 2;
   localparam int PRBS15_TAP_A = PRBS15_LEN - 1;
   localparam int PRBS15_TAP_B = PRBS15_LEN - 2;

   localparam logic [PRBS_HIST_W-1:0] PRBS_SEED = {PRBS_HIST_W{1'b1}};

   // Next sequence bit from the bit history; h[0] is the most recent bit.
   function automatic logic prbs_fb(input logic [PRBS_HIST_W-1:0] h, input logic sel);
      logic fb;
      if (sel) begin
         fb = h[PRBS15_TAP_A] ^ h[PRBS15_TAP_B];
      end else begin
         fb = h[PRBS7_TAP_A] ^ h[PRBS7_TAP_B];
      end
      return fb;
   endfunction

endpackage

// File: rtl/serdes_prbs_gen.sv
// Multi-bit PRBS7/PRBS15 word generator; the word register holds the presented
// word while the LFSR already holds the history needed for the following one.
module serdes_prbs_gen
   import serdes_bist_pkg::*;
#(
   parameter int DATA_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_i,
   input  logic              adv_i,
   input  logic              mode_i,
   output logic [DATA_W-1:0] data_o
);

   logic [PRBS_HIST_W-1:0] state_q, state_d;
   logic [DATA_W-1:0]      word_q, word_d;
   logic [PRBS_HIST_W-1:0] walk;
   logic [DATA_W-1:0]      word_nxt;

   // Unroll DATA_W LFSR steps, MSB of the word is the earliest bit.
   always_comb begin
      walk     = load_i ? PRBS_SEED : state_q;
      word_nxt = '0;
      for (int i = DATA_W-1; i >= 0; i--) begin
         word_nxt[i] = prbs_fb(walk, mode_i);
         walk        = {walk[PRBS_HIST_W-2:0], word_nxt[i]};
      end
      if (load_i || adv_i) begin
         state_d = walk;
         word_d  = word_nxt;
      end else begin
         state_d = state_q;
         word_d  = word_q;
      end
   end

   // LFSR history and presented word registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= '0;
         word_q  <= '0;
      end else begin
         state_q <= state_d;
         word_q  <= word_d;
      end
   end

   assign data_o = word_q;

endmodule

// File: rtl/serdes_lpbk_bist.sv
// Loopback BIST engine: PRBS TX word source, self-synchronising RX checker,
// sync/window/timeout sequencing and saturating bit-error count.
module serdes_lpbk_bist
   import serdes_bist_pkg::*;
#(
   parameter int DATA_W     = 4,
   parameter int ERR_CNT_W  = 16,
   parameter int CNT_W      = 16,
   parameter int LOCK_MATCH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start_i,
   input  logic                 stop_i,
   input  logic                 prbs_sel_i,
   input  logic                 inject_err_i,
   input  logic [CNT_W-1:0]     cfg_words_i,
   input  logic [CNT_W-1:0]     cfg_timeout_i,
   output logic [DATA_W-1:0]    tx_data_o,
   output logic                 tx_valid_o,
   input  logic                 tx_ready_i,
   input  logic [DATA_W-1:0]    rx_data_i,
   input  logic                 rx_valid_i,
   output logic                 busy_o,
   output logic                 synced_o,
   output logic                 done_o,
   output logic                 pass_o,
   output logic                 timeout_o,
   output logic [ERR_CNT_W-1:0] err_cnt_o
);

   localparam int POP_W     = $clog2(DATA_W + 1);
   localparam int ERR_SUM_W = ERR_CNT_W + POP_W;
   localparam int MC_W      = $clog2(LOCK_MATCH + 1);

   bist_state_e            state_q, state_d;
   logic                   mode_q, mode_d;
   logic                   busy_q, busy_d;
   logic                   tx_valid_q, tx_valid_d;
   logic                   synced_q, synced_d;
   logic                   done_q, done_d;
   logic                   pass_q, pass_d;
   logic                   timeout_q, timeout_d;
   logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;
   logic [CNT_W-1:0]       word_cnt_q, word_cnt_d;
   logic [CNT_W-1:0]       sync_cyc_q, sync_cyc_d;
   logic [MC_W-1:0]        match_q, match_d;
   logic [PRBS_HIST_W-1:0] hist_q, hist_d;
   logic                   inj_pend_q, inj_pend_d;
   logic                   tx_flip_q, tx_flip_d;

   logic                   gen_load, gen_adv, gen_mode;
   logic [DATA_W-1:0]      gen_data;
   logic                   tx_hs, start_go;
   logic [PRBS_HIST_W-1:0] chk_hist;
   logic [DATA_W-1:0]      rx_err;
   logic [POP_W-1:0]       rx_pop;
   logic [ERR_SUM_W-1:0]   err_sum;
   logic [ERR_CNT_W-1:0]   err_sat;
   logic [CNT_W-1:0]       words_eff;

   serdes_prbs_gen #(
      .DATA_W (DATA_W)
   ) u_gen (
      .clk    (clk),
      .rst_n  (rst_n),
      .load_i (gen_load),
      .adv_i  (gen_adv),
      .mode_i (gen_mode),
      .data_o (gen_data)
   );

   assign tx_hs     = tx_valid_q && tx_ready_i;
   assign start_go  = start_i && !stop_i && (state_q == ST_IDLE || state_q == ST_DONE);
   assign words_eff = (cfg_words_i == '0) ? CNT_W'(1) : cfg_words_i;

   // RX checker: predict each bit from the received history, then popcount and saturate.
   always_comb begin
      chk_hist = hist_q;
      rx_err   = '0;
      rx_pop   = '0;
      for (int i = DATA_W-1; i >= 0; i--) begin
         rx_err[i] = rx_data_i[i] ^ prbs_fb(chk_hist, mode_q);
         chk_hist  = {chk_hist[PRBS_HIST_W-2:0], rx_data_i[i]};
      end
      for (int i = 0; i < DATA_W; i++) begin
         rx_pop = rx_pop + POP_W'(rx_err[i]);
      end
      err_sum = ERR_SUM_W'(err_cnt_q) + ERR_SUM_W'(rx_pop);
      if (|err_sum[ERR_SUM_W-1:ERR_CNT_W]) begin
         err_sat = '1;
      end else begin
         err_sat = err_sum[ERR_CNT_W-1:0];
      end
   end

   // Run sequencing, counters and status next-state.
   always_comb begin
      state_d    = state_q;
      mode_d     = mode_q;
      synced_d   = synced_q;
      done_d     = done_q;
      pass_d     = pass_q;
      timeout_d  = timeout_q;
      err_cnt_d  = err_cnt_q;
      word_cnt_d = word_cnt_q;
      sync_cyc_d = sync_cyc_q;
      match_d    = match_q;
      hist_d     = rx_valid_i ? chk_hist : hist_q;
      inj_pend_d = inj_pend_q | inject_err_i;
      tx_flip_d  = tx_flip_q;
      gen_load   = 1'b0;
      gen_adv    = tx_hs;
      gen_mode   = mode_q;

      // A pending inject lands on the word loaded at the next handshake.
      if (tx_hs) begin
         tx_flip_d  = inj_pend_d;
         inj_pend_d = 1'b0;
      end else begin
         tx_flip_d  = tx_flip_q;
      end

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start_go) begin
               state_d    = ST_SYNC;
               mode_d     = prbs_sel_i;
               gen_mode   = prbs_sel_i;
               gen_load   = 1'b1;
               hist_d     = '0;
               synced_d   = 1'b0;
               done_d     = 1'b0;
               pass_d     = 1'b0;
               timeout_d  = 1'b0;
               err_cnt_d  = '0;
               word_cnt_d = '0;
               sync_cyc_d = '0;
               match_d    = '0;
               inj_pend_d = 1'b0;
               tx_flip_d  = 1'b0;
            end else begin
               state_d = state_q;
            end
         end
         ST_SYNC: begin
            sync_cyc_d = sync_cyc_q + CNT_W'(1);
            if (rx_valid_i) begin
               if (|rx_err) begin
                  match_d = '0;
               end else begin
                  match_d = match_q + MC_W'(1);
                  if (match_d == MC_W'(LOCK_MATCH)) begin
                     synced_d = 1'b1;
                     state_d  = ST_CHECK;
                  end else begin
                     state_d  = ST_SYNC;
                  end
               end
            end else begin
               match_d = match_q;
            end
            // Achieving sync in the same cycle wins over the timeout.
            if (state_d == ST_SYNC && cfg_timeout_i != '0 && sync_cyc_d == cfg_timeout_i) begin
               state_d   = ST_DONE;
               done_d    = 1'b1;
               timeout_d = 1'b1;
            end else begin
               timeout_d = timeout_q;
            end
         end
         ST_CHECK: begin
            if (rx_valid_i) begin
               err_cnt_d  = err_sat;
               word_cnt_d = word_cnt_q + CNT_W'(1);
               if (word_cnt_d >= words_eff) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
                  pass_d  = (err_cnt_d == '0);
               end else begin
                  state_d = ST_CHECK;
               end
            end else begin
               word_cnt_d = word_cnt_q;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (stop_i) begin
         state_d   = ST_IDLE;
         gen_load  = 1'b0;
         synced_d  = 1'b0;
         done_d    = 1'b0;
         pass_d    = 1'b0;
         timeout_d = 1'b0;
      end else begin
         gen_load  = gen_load;
      end

      busy_d     = (state_d == ST_SYNC) || (state_d == ST_CHECK);
      tx_valid_d = busy_d;
   end

   // Engine state and status registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         mode_q     <= 1'b0;
         busy_q     <= 1'b0;
         tx_valid_q <= 1'b0;
         synced_q   <= 1'b0;
         done_q     <= 1'b0;
         pass_q     <= 1'b0;
         timeout_q  <= 1'b0;
         err_cnt_q  <= '0;
         word_cnt_q <= '0;
         sync_cyc_q <= '0;
         match_q    <= '0;
         hist_q     <= '0;
         inj_pend_q <= 1'b0;
         tx_flip_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         mode_q     <= mode_d;
         busy_q     <= busy_d;
         tx_valid_q <= tx_valid_d;
         synced_q   <= synced_d;
         done_q     <= done_d;
         pass_q     <= pass_d;
         timeout_q  <= timeout_d;
         err_cnt_q  <= err_cnt_d;
         word_cnt_q <= word_cnt_d;
         sync_cyc_q <= sync_cyc_d;
         match_q    <= match_d;
         hist_q     <= hist_d;
         inj_pend_q <= inj_pend_d;
         tx_flip_q  <= tx_flip_d;
      end
   end

   assign tx_data_o  = gen_data ^ DATA_W'(tx_flip_q);
   assign tx_valid_o = tx_valid_q;
   assign busy_o     = busy_q;
   assign synced_o   = synced_q;
   assign done_o     = done_q;
   assign pass_o     = pass_q;
   assign timeout_o  = timeout_q;
   assign err_cnt_o  = err_cnt_q;

endmodule

// File: tb/tb_serdes_lpbk_bist.sv
// Directed bench: table of loopback runs plus hand-written timeout, stop and reset sequences.
module tb_serdes_lpbk_bist;

   localparam int DW   = 4;
   localparam int LOCK = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0, stop = 1'b0, prbs_sel = 1'b0, inject = 1'b0;
   logic [15:0]   cfg_words = 16'd1, cfg_timeout = 16'd0;
   logic          tx_ready = 1'b1, rxen = 1'b1, inv_en = 1'b0;

   logic [DW-1:0] tx_data, s_tx_data, s_rx_data;
   logic          tx_valid, busy, synced, done, pass, timeout;
   logic          s_tx_valid, s_busy, s_synced, s_done, s_pass, s_timeout;
   logic [15:0]   err_cnt;
   logic [3:0]    s_err;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   assign s_rx_data = s_tx_data ^ ((inv_en && s_synced) ? {DW{1'b1}} : {DW{1'b0}});

   serdes_lpbk_bist #(.DATA_W(DW), .ERR_CNT_W(16), .CNT_W(16), .LOCK_MATCH(LOCK)) u_dut (
      .clk(clk), .rst_n(rst_n), .start_i(start), .stop_i(stop), .prbs_sel_i(prbs_sel),
      .inject_err_i(inject), .cfg_words_i(cfg_words), .cfg_timeout_i(cfg_timeout),
      .tx_data_o(tx_data), .tx_valid_o(tx_valid), .tx_ready_i(tx_ready),
      .rx_data_i(tx_data), .rx_valid_i(tx_valid && tx_ready && rxen),
      .busy_o(busy), .synced_o(synced), .done_o(done), .pass_o(pass),
      .timeout_o(timeout), .err_cnt_o(err_cnt));

   serdes_lpbk_bist #(.DATA_W(DW), .ERR_CNT_W(4), .CNT_W(16), .LOCK_MATCH(LOCK)) u_sat (
      .clk(clk), .rst_n(rst_n), .start_i(start), .stop_i(stop), .prbs_sel_i(prbs_sel),
      .inject_err_i(inject), .cfg_words_i(cfg_words), .cfg_timeout_i(cfg_timeout),
      .tx_data_o(s_tx_data), .tx_valid_o(s_tx_valid), .tx_ready_i(tx_ready),
      .rx_data_i(s_rx_data), .rx_valid_i(s_tx_valid && tx_ready && rxen),
      .busy_o(s_busy), .synced_o(s_synced), .done_o(s_done), .pass_o(s_pass),
      .timeout_o(s_timeout), .err_cnt_o(s_err));

   typedef struct {
      logic sel;
      logic tog;
      int   words;
      logic inj;
      logic inv;
      logic exp_pass;
      int   exp_err;
      logic exp_s_pass;
      int   exp_s_err;
   } vec_t;

   vec_t tbl[6];

   // Reference sequence as an explicit bit list: b[n] = b[n-L] ^ b[n-L+1], seeded with ones.
   bit model_q[$];
   int model_len;

   task automatic model_reset(input logic sel);
      model_q.delete();
      for (int i = 0; i < 15; i++) model_q.push_back(1'b1);
      model_len = sel ? 15 : 7;
   endtask

   task automatic model_word(output logic [DW-1:0] w);
      bit nb;
      for (int i = DW-1; i >= 0; i--) begin
         nb = model_q[model_q.size()-model_len] ^ model_q[model_q.size()-model_len+1];
         model_q.push_back(nb);
         w[i] = nb;
      end
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic run_case(input int k);
      vec_t          v;
      int            hs_cnt, sync_at, cyc;
      logic          injected, phase, held_v, hs;
      logic [DW-1:0] held_w, exp_w;
      v = tbl[k];
      hs_cnt = 0; sync_at = -1; cyc = 0;
      injected = 1'b0; phase = 1'b0; held_v = 1'b0; held_w = '0;
      prbs_sel = v.sel; cfg_words = v.words[15:0]; cfg_timeout = 16'd0;
      rxen = 1'b1; inv_en = v.inv; tx_ready = 1'b1;
      pulse_start();
      model_reset(v.sel);
      chk($sformatf("row%0d_busy_start", k), busy, 1);
      chk($sformatf("row%0d_valid_start", k), tx_valid, 1);
      while (!(done && s_done) && cyc < 5000) begin
         tx_ready = v.tog ? phase : 1'b1;
         phase    = ~phase;
         if (held_v) chk($sformatf("row%0d_tx_hold", k), tx_data, held_w);
         held_v = tx_valid && !tx_ready;
         held_w = tx_data;
         hs     = tx_valid && tx_ready;
         if (hs) begin
            model_word(exp_w);
            if (!v.inj) chk($sformatf("row%0d_tx_word%0d", k, hs_cnt), tx_data, exp_w);
         end
         if (synced && sync_at < 0) sync_at = hs_cnt;
         if (v.inj && sync_at >= 0 && !injected && hs_cnt >= sync_at + 3) begin
            inject   = 1'b1;
            injected = 1'b1;
         end
         @(posedge clk); #1;
         inject = 1'b0;
         if (hs) hs_cnt++;
         cyc++;
      end
      tx_ready = 1'b1;
      chk($sformatf("row%0d_finished", k), (cyc < 5000), 1);
      if (!v.sel) chk($sformatf("row%0d_sync_latency", k), (sync_at >= 0 && sync_at <= LOCK + 2), 1);
      chk($sformatf("row%0d_done", k), done, 1);
      chk($sformatf("row%0d_pass", k), pass, v.exp_pass);
      chk($sformatf("row%0d_timeout", k), timeout, 0);
      chk($sformatf("row%0d_synced", k), synced, 1);
      chk($sformatf("row%0d_err_cnt", k), err_cnt, v.exp_err);
      chk($sformatf("row%0d_busy_done", k), busy, 0);
      chk($sformatf("row%0d_valid_done", k), tx_valid, 0);
      chk($sformatf("row%0d_sat_pass", k), s_pass, v.exp_s_pass);
      chk($sformatf("row%0d_sat_err", k), s_err, v.exp_s_err);
      inv_en = 1'b0;
   endtask

   initial begin
      //           sel   tog   words inj   inv   pass  err s_pass s_err
      tbl[0] = '{1'b0, 1'b0, 100, 1'b0, 1'b0, 1'b1, 0, 1'b1, 0};
      tbl[1] = '{1'b0, 1'b0, 100, 1'b1, 1'b0, 1'b0, 3, 1'b0, 3};
      tbl[2] = '{1'b1, 1'b1, 200, 1'b0, 1'b0, 1'b1, 0, 1'b1, 0};
      tbl[3] = '{1'b0, 1'b0, 20,  1'b0, 1'b1, 1'b1, 0, 1'b0, 15};
      tbl[4] = '{1'b1, 1'b0, 0,   1'b0, 1'b0, 1'b1, 0, 1'b1, 0};
      tbl[5] = '{1'b0, 1'b1, 50,  1'b1, 1'b0, 1'b0, 3, 1'b0, 3};

      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_tx_valid", tx_valid, 0);
      chk("rst_tx_data", tx_data, 0);
      chk("rst_synced", synced, 0);
      chk("rst_done", done, 0);
      chk("rst_pass", pass, 0);
      chk("rst_timeout", timeout, 0);
      chk("rst_err_cnt", err_cnt, 0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      for (int k = 0; k < 6; k++) run_case(k);

      // SYNC timeout with no RX traffic: done exactly 50 SYNC cycles after start.
      rxen = 1'b0; cfg_timeout = 16'd50; prbs_sel = 1'b0; cfg_words = 16'd10;
      pulse_start();
      chk("to_busy", busy, 1);
      repeat (49) @(posedge clk);
      #1;
      chk("to_done_early", done, 0);
      @(posedge clk); #1;
      chk("to_done", done, 1);
      chk("to_timeout", timeout, 1);
      chk("to_pass", pass, 0);
      chk("to_synced", synced, 0);
      chk("to_busy_low", busy, 0);
      rxen = 1'b1; cfg_timeout = 16'd0;

      // Stop in the middle of CHECK, then a clean rerun.
      cfg_words = 16'd100;
      pulse_start();
      for (int c = 0; c < 200 && !synced; c++) begin
         @(posedge clk); #1;
      end
      chk("stop_reached_sync", synced, 1);
      repeat (5) @(posedge clk);
      #1;
      stop = 1'b1;
      @(posedge clk); #1;
      stop = 1'b0;
      chk("stop_tx_valid", tx_valid, 0);
      chk("stop_busy", busy, 0);
      chk("stop_done", done, 0);
      chk("stop_synced", synced, 0);
      run_case(0);

      // Asynchronous reset mid-run takes effect before the next clock edge.
      pulse_start();
      repeat (20) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("arst_busy", busy, 0);
      chk("arst_tx_valid", tx_valid, 0);
      chk("arst_synced", synced, 0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
